// File: rtl/servo_array_ctrl.sv
// N-channel servo PWM controller: shared 1 us timebase and frame counter, per-channel
// sweep with toggle/freeze, and a valid/ready stream logging post-update positions.
module servo_array_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int N_CH      = 4,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int STEP_US   = 10
) (
    input  logic            mclk,
    input  logic            rst,
    input  logic [N_CH-1:0] toggle,
    input  logic [N_CH-1:0] freeze,
    output logic [N_CH-1:0] pwm,
    output logic [N_CH-1:0] dir,
    output logic [15:0]     log_data,
    output logic            log_valid,
    input  logic            log_ready,
    output logic            log_overrun
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [11:0]        MID    = 12'((MIN_US + MAX_US) / 2);
    localparam logic signed [15:0] MIN_S  = 16'(MIN_US);
    localparam logic signed [15:0] MAX_S  = 16'(MAX_US);
    localparam logic signed [15:0] STEP_S = 16'(STEP_US);

    // Returns {dir, pos}: one step in direction up, clamped to the limits, which also
    // force the direction so the sweep bounces off each end.
    function automatic logic [12:0] step_clamp(input logic [11:0] p, input logic up);
        logic signed [15:0] nxt;
        nxt = $signed({4'b0000, p}) + (up ? STEP_S : -STEP_S);
        if (nxt >= MAX_S)
            step_clamp = {1'b0, 12'(MAX_US)};
        else if (nxt <= MIN_S)
            step_clamp = {1'b1, 12'(MIN_US)};
        else
            step_clamp = {up, nxt[11:0]};
    endfunction

    logic [PW-1:0]   psc_q, psc_d;
    logic [14:0]     fcnt_q, fcnt_d;
    logic            tick, frame_start;
    logic [N_CH-1:0] tog_s1_q, tog_s2_q, tog_s3_q, pend_eff;
    logic [N_CH-1:0] pend_q, pend_d, dir_q, dir_d, pwm_q, pwm_d;
    logic [11:0]     pos_q [N_CH];
    logic [11:0]     pos_d [N_CH];
    logic [11:0]     shadow_q [N_CH];
    logic [11:0]     shadow_d [N_CH];
    logic [11:0]     snap_q [N_CH];
    logic [11:0]     snap_d [N_CH];
    logic [IW-1:0]   idx_q, idx_d, idx_nxt;
    logic            lvalid_q, lvalid_d, ovr_q, ovr_d;
    logic [15:0]     ldata_q, ldata_d;

    assign tick        = (psc_q == PW'(DIV - 1));
    assign frame_start = tick && (fcnt_q == 15'(PERIOD_US - 1));
    assign pend_eff    = pend_q | (tog_s2_q & ~tog_s3_q);
    assign idx_nxt     = idx_q + IW'(1);

    always_comb begin
        psc_d  = tick ? '0 : psc_q + PW'(1);
        fcnt_d = fcnt_q;
        if (tick)
            fcnt_d = frame_start ? '0 : fcnt_q + 15'd1;
    end

    // Shadow takes the pre-update position so the width is constant for a whole frame.
    always_comb begin
        pend_d = pend_eff;
        dir_d  = dir_q;
        pwm_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos_d[i]    = pos_q[i];
            shadow_d[i] = shadow_q[i];
            if (frame_start) begin
                shadow_d[i] = pos_q[i];
                if (!freeze[i]) begin
                    {dir_d[i], pos_d[i]} = step_clamp(pos_q[i], dir_q[i] ^ pend_eff[i]);
                    pend_d[i] = 1'b0;
                end
            end
            pwm_d[i] = (fcnt_q < {3'b000, shadow_q[i]});
        end
    end

    // A frame start during an active burst is dropped; the burst keeps its own snapshot.
    always_comb begin
        lvalid_d = lvalid_q;
        idx_d    = idx_q;
        ldata_d  = ldata_q;
        snap_d   = snap_q;
        ovr_d    = 1'b0;
        if (lvalid_q && log_ready) begin
            if (idx_q == IW'(N_CH - 1)) begin
                lvalid_d = 1'b0;
            end else begin
                idx_d   = idx_nxt;
                ldata_d = {4'(idx_nxt), snap_q[idx_nxt]};
            end
        end
        if (frame_start) begin
            if (lvalid_q) begin
                ovr_d = 1'b1;
            end else begin
                lvalid_d = 1'b1;
                idx_d    = '0;
                snap_d   = pos_d;
                ldata_d  = {4'd0, pos_d[0]};
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            psc_q    <= '0;
            fcnt_q   <= '0;
            tog_s1_q <= '0;
            tog_s2_q <= '0;
            tog_s3_q <= '0;
            pend_q   <= '0;
            dir_q    <= '1;
            pwm_q    <= '0;
            idx_q    <= '0;
            lvalid_q <= 1'b0;
            ldata_q  <= '0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i]    <= MID;
                shadow_q[i] <= MID;
            end
        end else begin
            psc_q    <= psc_d;
            fcnt_q   <= fcnt_d;
            tog_s1_q <= toggle;
            tog_s2_q <= tog_s1_q;
            tog_s3_q <= tog_s2_q;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            pwm_q    <= pwm_d;
            idx_q    <= idx_d;
            lvalid_q <= lvalid_d;
            ldata_q  <= ldata_d;
            ovr_q    <= ovr_d;
            pos_q    <= pos_d;
            shadow_q <= shadow_d;
        end
    end

    always_ff @(posedge mclk) begin
        snap_q <= snap_d;
    end

    assign pwm         = pwm_q;
    assign dir         = dir_q;
    assign log_data    = ldata_q;
    assign log_valid   = lvalid_q;
    assign log_overrun = ovr_q;
endmodule

// File: tb/tb_servo_array_ctrl.sv
// Bench for servo_array_ctrl: directed steps plus random toggles/freezes/ready,
// checked every cycle against a frame-level behavioural model.
module tb_servo_array_ctrl;
    localparam int CLK_HZ = 2_000_000;
    localparam int N      = 4;
    localparam int PER    = 100;
    localparam int MIN    = 20;
    localparam int MAX    = 60;
    localparam int STEP   = 10;
    localparam int CPF    = PER * (CLK_HZ / 1_000_000);

    logic         mclk;
    logic         rst;
    logic [N-1:0] toggle, freeze, pwm, dir;
    logic [15:0]  log_data;
    logic         log_valid, log_ready, log_overrun;

    servo_array_ctrl #(
        .CLK_HZ(CLK_HZ), .N_CH(N), .PERIOD_US(PER),
        .MIN_US(MIN), .MAX_US(MAX), .STEP_US(STEP)
    ) dut (
        .mclk(mclk), .rst(rst), .toggle(toggle), .freeze(freeze),
        .pwm(pwm), .dir(dir), .log_data(log_data), .log_valid(log_valid),
        .log_ready(log_ready), .log_overrun(log_overrun)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int          total = 0;
    int          bad   = 0;
    int          m_pos [N];
    int          m_shadow [N];
    bit          m_dir [N];
    bit          m_pend [N];
    logic [15:0] exp_q [$];
    bit          exp_ovr;

    logic [N-1:0] cfg_frz, cfg_tog;
    bit           cfg_twice;
    int           cfg_rdy, cfg_lo_a, cfg_lo_b;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_dir();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_dir[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pos[i]    = (MIN + MAX) / 2;
            m_shadow[i] = (MIN + MAX) / 2;
            m_dir[i]    = 1'b1;
            m_pend[i]   = 1'b0;
        end
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pwm"}, 16'(pwm), 16'h0);
        chk({tag, "_dir"}, 16'(dir), 16'hF);
        chk({tag, "_valid"}, 16'(log_valid), 16'h0);
        chk({tag, "_data"}, log_data, 16'h0);
        chk({tag, "_ovr"}, 16'(log_overrun), 16'h0);
    endtask

    // The sweep rules applied once per frame boundary, plus the log snapshot decision.
    task automatic model_frame_end(input bit busy);
        int  n;
        bit  d;
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = m_pos[i];
            if (!cfg_frz[i]) begin
                d = m_dir[i] ^ m_pend[i];
                n = d ? m_pos[i] + STEP : m_pos[i] - STEP;
                if (n >= MAX) begin
                    m_pos[i] = MAX; m_dir[i] = 1'b0;
                end else if (n <= MIN) begin
                    m_pos[i] = MIN; m_dir[i] = 1'b1;
                end else begin
                    m_pos[i] = n;   m_dir[i] = d;
                end
                m_pend[i] = 1'b0;
            end
        end
        exp_ovr = busy;
        if (!busy)
            for (int i = 0; i < N; i++) exp_q.push_back({4'(i), 12'(m_pos[i])});
    endtask

    // Runs one frame, entered and left at the negedge right after a frame boundary edge.
    task automatic run_frame();
        logic [N-1:0] ev;
        bit           busy;
        busy   = 1'b0;
        freeze = cfg_frz;
        for (int c = 0; c < CPF; c++) begin
            for (int i = 0; i < N; i++) ev[i] = (c >= 1) && (c <= 2 * m_shadow[i]);
            chk("pwm", 16'(pwm), 16'(ev));
            chk("overrun", 16'(log_overrun), 16'((c == 0) && exp_ovr));
            chk("log_valid", 16'(log_valid), 16'(exp_q.size() > 0));
            if (exp_q.size() > 0 && log_valid) chk("log_data", log_data, exp_q[0]);
            if (c == 0 || c == CPF / 2) chk("dir", 16'(dir), 16'(model_dir()));
            case (cfg_rdy)
                0:       log_ready = 1'b1;
                1:       log_ready = 1'($urandom_range(0, 1));
                2:       log_ready = 1'b0;
                default: log_ready = !(c >= cfg_lo_a && c < cfg_lo_b);
            endcase
            if (c == 30 || (cfg_twice && c == 60)) begin
                toggle = cfg_tog;
                for (int i = 0; i < N; i++) if (cfg_tog[i]) m_pend[i] = 1'b1;
            end
            if (c == 40 || c == 70) toggle = '0;
            if (c == CPF - 1) busy = (exp_q.size() > 0);
            if (log_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            @(negedge mclk);
        end
        model_frame_end(busy);
    endtask

    initial begin
        int n;
        rst = 1'b1; toggle = '0; freeze = '0; log_ready = 1'b0;
        cfg_frz = '0; cfg_tog = '0; cfg_twice = 1'b0; cfg_rdy = 0; cfg_lo_a = 0; cfg_lo_b = 0;
        model_reset();
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check_reset_state("reset");
        rst = 1'b0;

        // Free sweep through both limits with the log always drained.
        repeat (12) run_frame();

        // Double toggle on ch1 while it sits at 50 going up: one reversal only.
        n = 0;
        while (!(m_pos[1] == 50 && m_dir[1]) && n < 20) begin
            run_frame();
            n++;
        end
        chk("seek_tog_bound", 16'(n < 20), 16'h1);
        cfg_tog = 4'b0010; cfg_twice = 1'b1;
        run_frame();
        cfg_tog = '0; cfg_twice = 1'b0;
        chk("tog_dir1", 16'(dir[1]), 16'h0);
        run_frame();

        // Freeze ch2 at 30 for three boundaries with a toggle landing while frozen.
        n = 0;
        while (m_pos[2] != 30 && n < 20) begin
            run_frame();
            n++;
        end
        chk("seek_frz_bound", 16'(n < 20), 16'h1);
        cfg_frz = 4'b0100; cfg_tog = 4'b0100;
        run_frame();
        cfg_tog = '0;
        repeat (2) run_frame();
        cfg_frz = '0;
        repeat (2) run_frame();

        // Ready held low for 5 cycles on word 1.
        cfg_rdy = 3; cfg_lo_a = 1; cfg_lo_b = 6;
        run_frame();

        // Ready low across a boundary: overrun, then the old burst resumes.
        cfg_rdy = 2;
        run_frame();
        chk("ovr_pulse", 16'(log_overrun), 16'h1);
        chk("ovr_old_word", 16'(log_data[15:12]), 16'h0);
        cfg_rdy = 3; cfg_lo_a = 0; cfg_lo_b = 20;
        run_frame();
        cfg_rdy = 0;
        repeat (2) run_frame();

        // Random toggles, freezes and ready.
        repeat (12) begin
            cfg_rdy   = 1;
            cfg_tog   = 4'($urandom_range(0, 15));
            cfg_twice = 1'($urandom_range(0, 1));
            cfg_frz   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            run_frame();
        end
        cfg_rdy = 0; cfg_tog = '0; cfg_twice = 1'b0; cfg_frz = '0;
        repeat (2) run_frame();

        // Reset in the middle of a stalled burst.
        log_ready = 1'b0;
        repeat (2) @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        check_reset_state("midreset");
        rst = 1'b0;
        model_reset();
        repeat (2) run_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
